// File: rtl/imem_program_loader.sv
// Purpose: gathers UART bytes into 32-bit big-endian instructions and writes each one to the next
//          instruction-memory word. The CPU is stalled until the load finishes; the address port then goes to the PC.
// Latency: a write strobe one edge after the 4th byte, and load_done one edge after the final write.
// Backpressure: none. Bytes are accepted whenever they arrive in RECV or WRITE and are dropped in IDLE and DONE.
//
// Ports:
//   i_clk, i_reset        clock and synchronous active-high reset
//   i_start               load request pulse; acted on only when no load is in progress
//   i_rx_data/i_rx_valid  received byte and its one-cycle strobe
//   i_pc_addr             PC word address; drives the memory address once loading is done
//   o_imem_addr/_wr_en/_wr_data   instruction-memory port
//   o_cpu_hold            stalls the CPU while a load is pending or running
//   o_load_done           loading has finished
//   o_word_count          words written by the current or last load
module imem_program_loader #(
    parameter int                    MEM_SIZE    = 5,
    parameter int                    ADDR_LENGTH = 32,
    parameter int                    DATA_LENGTH = 32,
    parameter logic [DATA_LENGTH-1:0] HALT_WORD  = 32'hFFFFFFFF
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic [7:0]             i_rx_data,
    input  logic                   i_rx_valid,
    input  logic [ADDR_LENGTH-1:0] i_pc_addr,
    output logic [ADDR_LENGTH-1:0] o_imem_addr,
    output logic                   o_imem_wr_en,
    output logic [DATA_LENGTH-1:0] o_imem_wr_data,
    output logic                   o_cpu_hold,
    output logic                   o_load_done,
    output logic [ADDR_LENGTH-1:0] o_word_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_LENGTH-1:0] MEM_SIZE_W = ADDR_LENGTH'(MEM_SIZE);

    state_t                 state, state_nxt;
    logic [1:0]             byte_cnt, byte_cnt_nxt;
    logic [ADDR_LENGTH-1:0] word_cnt, word_cnt_nxt;
    logic [DATA_LENGTH-1:0] shift_reg, shift_nxt;
    logic                   wr_en_nxt;
    logic [DATA_LENGTH-1:0] wr_data_nxt;
    logic                   hold_nxt;
    logic                   done_nxt;
    logic                   start_ok;
    logic                   capture;

    // A start is honoured only when no load is in progress.
    assign start_ok = i_start && (state == IDLE || state == DONE);
    // Bytes are taken in RECV and in WRITE; a WRITE-cycle byte becomes byte 0 of the next word.
    assign capture  = i_rx_valid && (state == RECV || state == WRITE);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (i_start) state_nxt = RECV;
            RECV:  if (i_rx_valid && byte_cnt == 2'd3) state_nxt = WRITE;
            // o_imem_wr_data holds the word being written in this cycle.
            WRITE: if (o_imem_wr_data == HALT_WORD || (word_cnt + ADDR_LENGTH'(1)) == MEM_SIZE_W)
                       state_nxt = DONE;
                   else
                       state_nxt = RECV;
            DONE:  if (i_start) state_nxt = RECV;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs and the datapath
    always_comb begin
        byte_cnt_nxt = byte_cnt;
        word_cnt_nxt = word_cnt;
        shift_nxt    = shift_reg;
        wr_en_nxt    = 1'b0;
        wr_data_nxt  = o_imem_wr_data;

        if (start_ok) begin
            byte_cnt_nxt = 2'd0;
            word_cnt_nxt = '0;
            shift_nxt    = '0;
        end

        if (capture) begin
            // Shifting in at the LSB leaves the first byte in [31:24].
            shift_nxt    = {shift_reg[DATA_LENGTH-9:0], i_rx_data};
            byte_cnt_nxt = byte_cnt + 2'd1;
        end

        if (state == RECV && capture && byte_cnt == 2'd3) begin
            wr_en_nxt   = 1'b1;
            wr_data_nxt = shift_nxt;
        end

        if (state == WRITE) begin
            word_cnt_nxt = word_cnt + ADDR_LENGTH'(1);
        end

        hold_nxt = (state_nxt != DONE);
        done_nxt = (state_nxt == DONE);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            byte_cnt       <= 2'd0;
            word_cnt       <= '0;
            shift_reg      <= '0;
            o_imem_wr_en   <= 1'b0;
            o_imem_wr_data <= '0;
            o_cpu_hold     <= 1'b1;
            o_load_done    <= 1'b0;
        end else begin
            byte_cnt       <= byte_cnt_nxt;
            word_cnt       <= word_cnt_nxt;
            shift_reg      <= shift_nxt;
            o_imem_wr_en   <= wr_en_nxt;
            o_imem_wr_data <= wr_data_nxt;
            o_cpu_hold     <= hold_nxt;
            o_load_done    <= done_nxt;
        end
    end

    assign o_word_count = word_cnt;

    // The PC owns the memory port only after loading has finished.
    assign o_imem_addr = (state == DONE) ? i_pc_addr : word_cnt;

endmodule

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
- Sequences the instruction memory before execution. Collects program bytes from the UART receiver and packs each group of four into a 32-bit instruction. Writes each instruction into consecutive word addresses.
- Owns the instruction-memory address port while loading and holds the CPU in stall. After loading it hands the port to the PC and releases the CPU.
- Sits between the debug UART RX, the PC stage and the instruction memory.

Parameters:
- MEM_SIZE, 5, number of instruction words in memory; word addresses run 0..MEM_SIZE-1
- ADDR_LENGTH, 32, width of the instruction-memory address
- DATA_LENGTH, 32, instruction width; exactly 4 bytes
- HALT_WORD, 32'hFFFFFFFF, instruction value that terminates loading

Ports:
- i_clk  in  1  single clock; all state changes on the rising edge
- i_reset  in  1  synchronous, active-high reset
- i_start  in  1  one-cycle pulse that begins a load; honoured only in IDLE or DONE
- i_rx_data  in  8  received byte
- i_rx_valid  in  1  one-cycle strobe; i_rx_data is valid in that cycle
- i_pc_addr  in  ADDR_LENGTH  word address from the PC
- o_imem_addr  out  ADDR_LENGTH  address to instruction memory
- o_imem_wr_en  out  1  write strobe to instruction memory
- o_imem_wr_data  out  DATA_LENGTH  assembled instruction
- o_cpu_hold  out  1  stalls PC/pipeline while high
- o_load_done  out  1  high once loading has finished, until the next i_start or reset
- o_word_count  out  ADDR_LENGTH  number of words written in the current or last load

Behaviour:
- States: IDLE, RECV, WRITE, DONE. All outputs are registered except o_imem_addr.
- Reset (i_reset=1 at an edge), from any state including mid-load:
  - state goes to IDLE; byte counter, word counter and shift register go to 0
  - o_imem_wr_en=0, o_imem_wr_data=0, o_load_done=0, o_word_count=0
  - o_cpu_hold=1
  - memory words already written are not cleared
- IDLE:
  - o_cpu_hold=1.
  - i_start goes to RECV; byte counter and word counter clear.
  - i_rx_valid is ignored.
- RECV:
  - Each i_rx_valid shifts i_rx_data into the LSB of the shift register. The first byte received ends up as bits [31:24] (big-endian).
  - The byte counter increments modulo 4.
  - On the 4th byte the state goes to WRITE on the next edge.
- WRITE (exactly one cycle):
  - o_imem_wr_en=1, o_imem_wr_data=assembled word, o_imem_addr=word counter.
  - The word counter increments at the end of the cycle; o_word_count tracks it.
  - An i_rx_valid in this cycle is captured as byte 0 of the next word and is not dropped.
  - Next state is DONE if the word equals HALT_WORD or the incremented count equals MEM_SIZE. Otherwise next state is RECV.
  - The HALT_WORD itself is written to memory.
- DONE:
  - o_load_done=1, o_cpu_hold=0, o_imem_wr_en=0.
  - i_rx_valid is ignored.
  - i_start re-enters RECV: clears counters and o_load_done, asserts o_cpu_hold.
- Address mux (combinational):
  - o_imem_addr = i_pc_addr in DONE.
  - o_imem_addr = word counter in IDLE, RECV and WRITE.
- Latency: wr_en rises on the edge after the 4th byte's i_rx_valid cycle. o_load_done rises one edge after the terminating WRITE.
- Simultaneous i_reset and i_start: reset wins.
- i_start while in RECV or WRITE is ignored (no restart mid-load).
- A partial word (fewer than 4 bytes) is never written. It persists until completed or until reset.

Test Plan:
- Reset, i_start, then bytes 0x20,0x08,0x00,0x05,0xFF,0xFF,0xFF,0xFF -> required response:
  - write of 0x20080005 at addr 0, then 0xFFFFFFFF at addr 1
  - o_word_count=2, o_load_done=1, o_cpu_hold=0
- Five non-halt words with MEM_SIZE=5 -> required response:
  - writes at addresses 0..4
  - DONE after the 5th write
  - a 6th word of bytes produces no wr_en
- In DONE, drive i_pc_addr=3 -> o_imem_addr=3 and o_imem_wr_en=0. In RECV, o_imem_addr equals the word counter regardless of i_pc_addr.
- Assert i_reset after 6 bytes (word 0 written, 2 bytes pending), then i_start and 4 new bytes -> new word written at addr 0 from the new bytes only.
- i_rx_valid in the same cycle as a WRITE, e.g. bytes 0x11,0x22,0x33,0x44 then 0xAA landing in the WRITE cycle, followed by 0xBB,0xCC,0xDD -> second write is 0xAABBCCDD at addr 1.
- i_start pulsed mid-RECV -> ignored, counters unchanged. i_start together with i_reset -> state IDLE, o_load_done=0.
